// File: rtl/burst_sram_slave_pkg.sv
// Shared definitions for the burst SRAM slave: FSM states, burst limits, byte-lane masks.
package burst_sram_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_FETCH,
    RD_DATA,
    RD_END,
    WR_DATA,
    WR_WAIT_END,
    ERR
  } state_e;

  localparam int unsigned BURST_MAX = 256;
  localparam int unsigned CNT_W     = $clog2(BURST_MAX) + 1;
  localparam logic [3:0]  BE_ALL    = '1;

endpackage

// File: rtl/burst_sram_slave_array.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables, 1-cycle read latency.
module burst_sram_array #(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clock,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem [2**ADDR_BITS];
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we_i && be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_sram_slave.sv
// Word-addressed SRAM burst slave: window decode, read streaming, write absorption,
// optional periodic busy insertion on write bursts.
module burst_sram_slave
  import burst_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int unsigned ADDR_BITS    = 10,
  parameter int unsigned BUSY_PERIOD  = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic [7:0]  burstSizeIn,
  input  logic        readNotWriteIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busErrorOut,
  output logic        busyOut
);

  localparam int unsigned DEPTH     = 2**ADDR_BITS;
  localparam logic [CNT_W-1:0] BUSY_LAST = (BUSY_PERIOD == 0) ? '0 : CNT_W'(BUSY_PERIOD - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     bcnt_q, bcnt_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [7:0]           burst_q, burst_d;
  logic [3:0]           be_q, be_d;
  logic                 busy_q, busy_d;
  logic                 ram_we;
  logic [31:0]          ram_rdata;

  logic                 hit, bad, last, accept, err_fire;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          span;

  assign hit    = addressDataIn[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2];
  assign idx    = addressDataIn[ADDR_BITS+1:2];
  assign span   = 32'(idx) + 32'(burstSizeIn);
  assign bad    = (addressDataIn[1:0] != 2'b00) || (span >= DEPTH);
  assign last   = cnt_q == {1'b0, burst_q};
  assign accept = (state_q == WR_DATA) && dataValidIn && !busy_q && !endTransactionIn;
  // ERR waits one cycle (cnt_q == 0) so the error pulse lands two cycles after begin.
  assign err_fire = (state_q == ERR) && (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    be_d    = be_q;
    busy_d  = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (beginTransactionIn && hit) begin
          burst_d = burstSizeIn;
          be_d    = byteEnablesIn;
          ptr_d   = idx;
          cnt_d   = '0;
          bcnt_d  = '0;
          if (bad)                 state_d = ERR;
          else if (readNotWriteIn) state_d = RD_FETCH;
          else                     state_d = WR_DATA;
        end
      end
      ERR: begin
        if (cnt_q == '0) cnt_d = 1;
        else             state_d = IDLE;
      end
      RD_FETCH: begin
        ptr_d   = ptr_q + 1'b1;
        state_d = endTransactionIn ? IDLE : RD_DATA;
      end
      RD_DATA: begin
        // Address runs one word ahead of the beat being presented.
        ptr_d = ptr_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (endTransactionIn) state_d = IDLE;
        else if (last)        state_d = RD_END;
      end
      RD_END: state_d = IDLE;
      WR_DATA: begin
        if (endTransactionIn) begin
          state_d = IDLE;
        end else if (accept) begin
          ram_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (last) begin
            state_d = WR_WAIT_END;
          end else if (BUSY_PERIOD != 0) begin
            if (bcnt_q == BUSY_LAST) begin
              bcnt_d = '0;
              busy_d = 1'b1;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
      end
      WR_WAIT_END: if (endTransactionIn) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      be_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      be_q    <= be_d;
      busy_q  <= busy_d;
    end
  end

  burst_sram_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clock   (clock),
    .we_i    (ram_we),
    .be_i    (be_q),
    .addr_i  (ptr_q),
    .wdata_i (addressDataIn),
    .rdata_o (ram_rdata)
  );

  assign dataValidOut      = state_q == RD_DATA;
  assign addressDataOut    = dataValidOut ? ram_rdata : '0;
  assign endTransactionOut = (state_q == RD_END) || err_fire;
  assign busErrorOut       = err_fire;
  assign busyOut           = busy_q;

endmodule

// File: tb/tb_burst_sram_slave.sv
// Directed bench for burst_sram_slave: one instance without busy insertion, one with BUSY_PERIOD=2.
module tb_burst_sram_slave;
  import burst_sram_slave_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        beg_a = 1'b0, beg_b = 1'b0;
  logic [31:0] ad_in = '0;
  logic [3:0]  be_in = '0;
  logic [7:0]  bs_in = '0;
  logic        rnw_in = 1'b0;
  logic        dv_in = 1'b0;
  logic        et_in = 1'b0;

  logic [31:0] ad_a, ad_b;
  logic        dv_a, dv_b, eot_a, eot_b, berr_a, berr_b, busy_a, busy_b;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  logic [31:0] wq[$];
  logic [31:0] rq[$];
  int          busy_pos[$];

  always #5 clk = ~clk;

  burst_sram_slave dut_a (
    .clock(clk), .reset(rst), .beginTransactionIn(beg_a), .addressDataIn(ad_in),
    .byteEnablesIn(be_in), .burstSizeIn(bs_in), .readNotWriteIn(rnw_in),
    .dataValidIn(dv_in), .endTransactionIn(et_in), .addressDataOut(ad_a),
    .dataValidOut(dv_a), .endTransactionOut(eot_a), .busErrorOut(berr_a), .busyOut(busy_a)
  );

  burst_sram_slave #(.BUSY_PERIOD(2)) dut_b (
    .clock(clk), .reset(rst), .beginTransactionIn(beg_b), .addressDataIn(ad_in),
    .byteEnablesIn(be_in), .burstSizeIn(bs_in), .readNotWriteIn(rnw_in),
    .dataValidIn(dv_in), .endTransactionIn(et_in), .addressDataOut(ad_b),
    .dataValidOut(dv_b), .endTransactionOut(eot_b), .busErrorOut(berr_b), .busyOut(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] o_ad(input bit sel);   return sel ? ad_b : ad_a;     endfunction
  function automatic logic        o_dv(input bit sel);   return sel ? dv_b : dv_a;     endfunction
  function automatic logic        o_eot(input bit sel);  return sel ? eot_b : eot_a;   endfunction
  function automatic logic        o_berr(input bit sel); return sel ? berr_b : berr_a; endfunction
  function automatic logic        o_busy(input bit sel); return sel ? busy_b : busy_a; endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle begin; returns one cycle later.
  task automatic begin_txn(input bit sel, input logic [31:0] a, input logic [3:0] be,
                           input logic [7:0] bs, input logic rnw);
    beg_a = !sel; beg_b = sel; ad_in = a; be_in = be; bs_in = bs; rnw_in = rnw;
    tick();
    beg_a = 1'b0; beg_b = 1'b0; ad_in = '0;
  endtask

  task automatic write_burst(input bit sel, input logic [31:0] a, input logic [3:0] be,
                             input logic [7:0] bs);
    int acc = 0;
    int cyc = 0;
    logic b;
    busy_pos.delete();
    begin_txn(sel, a, be, bs, 1'b0);
    while (acc < int'(bs) + 1 && cyc < 64) begin
      ad_in = wq[acc];
      dv_in = 1'b1;
      @(negedge clk);
      b = o_busy(sel);
      if (b) busy_pos.push_back(acc);
      tick();
      if (!b) acc++;
      cyc++;
    end
    dv_in = 1'b0; ad_in = '0;
    chk("wr_beats", 32'(acc), 32'(int'(bs) + 1));
    et_in = 1'b1;
    tick();
    et_in = 1'b0;
  endtask

  task automatic read_burst(input bit sel, input logic [31:0] a, input logic [7:0] bs);
    begin_txn(sel, a, '0, bs, 1'b1);
    @(negedge clk);
    chk("rd_fetch_dv", 32'(o_dv(sel)), 32'd0);
    chk("rd_fetch_ad", o_ad(sel), 32'd0);
    tick();
    for (int i = 0; i <= int'(bs); i++) begin
      @(negedge clk);
      chk("rd_dv", 32'(o_dv(sel)), 32'd1);
      chk("rd_data", o_ad(sel), rq[i]);
      chk("rd_eot_early", 32'(o_eot(sel)), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("rd_eot", 32'(o_eot(sel)), 32'd1);
    chk("rd_end_dv", 32'(o_dv(sel)), 32'd0);
    chk("rd_end_ad", o_ad(sel), 32'd0);
    chk("rd_end_berr", 32'(o_berr(sel)), 32'd0);
    tick();
    @(negedge clk);
    chk("rd_eot_pulse", 32'(o_eot(sel)), 32'd0);
    tick();
  endtask

  task automatic err_txn(input logic [31:0] a, input logic [7:0] bs, input logic rnw);
    begin_txn(1'b0, a, BE_ALL, bs, rnw);
    dv_in = !rnw; ad_in = 32'hDEAD_0001;
    @(negedge clk);
    chk("err_t1_eot", 32'(eot_a), 32'd0);
    chk("err_t1_berr", 32'(berr_a), 32'd0);
    tick();
    ad_in = 32'hDEAD_0002;
    @(negedge clk);
    chk("err_t2_eot", 32'(eot_a), 32'd1);
    chk("err_t2_berr", 32'(berr_a), 32'd1);
    chk("err_t2_dv", 32'(dv_a), 32'd0);
    tick();
    dv_in = 1'b0; ad_in = '0;
    @(negedge clk);
    chk("err_t3_eot", 32'(eot_a), 32'd0);
    chk("err_t3_berr", 32'(berr_a), 32'd0);
    tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dv_a", 32'(dv_a), 32'd0);
    chk("rst_ad_a", ad_a, 32'd0);
    chk("rst_eot_a", 32'(eot_a), 32'd0);
    chk("rst_berr_a", 32'(berr_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_outs_b", {ad_b[27:0], dv_b, eot_b, berr_b, busy_b}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Four-word burst write then read back.
    wq = '{32'h11, 32'h22, 32'h33, 32'h44};
    write_burst(1'b0, 32'h5000_0010, BE_ALL, 8'd3);
    rq = wq;
    read_burst(1'b0, 32'h5000_0010, 8'd3);

    // Partial byte-lane write.
    wq = '{32'hFFFF_FFFF};
    write_burst(1'b0, 32'h5000_0040, BE_ALL, 8'd0);
    wq = '{32'hAABB_CCDD};
    write_burst(1'b0, 32'h5000_0040, 4'b0011, 8'd0);
    rq = '{32'hFFFF_CCDD};
    read_burst(1'b0, 32'h5000_0040, 8'd0);

    // Busy insertion after every 2nd accepted beat, not after the final beat.
    wq = '{32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6};
    write_burst(1'b1, 32'h5000_0080, BE_ALL, 8'd5);
    chk("busy_count", 32'(busy_pos.size()), 32'd2);
    chk("busy_pos0", busy_pos.size() > 0 ? 32'(busy_pos[0]) : 32'hFFFF_FFFF, 32'd2);
    chk("busy_pos1", busy_pos.size() > 1 ? 32'(busy_pos[1]) : 32'hFFFF_FFFF, 32'd4);
    @(negedge clk);
    chk("busy_idle", 32'(busy_b), 32'd0);
    tick();
    rq = wq;
    read_burst(1'b1, 32'h5000_0080, 8'd5);

    // Overrun write error leaves RAM untouched; misaligned read errors.
    wq = '{32'h1234_5678};
    write_burst(1'b0, 32'h5000_0FFC, BE_ALL, 8'd0);
    err_txn(32'h5000_0FFC, 8'd1, 1'b0);
    rq = '{32'h1234_5678};
    read_burst(1'b0, 32'h5000_0FFC, 8'd0);
    err_txn(32'h5000_0002, 8'd0, 1'b1);

    // Address miss: no response.
    begin_txn(1'b0, 32'h6000_0000, BE_ALL, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("miss_quiet", {ad_a[28:0], dv_a, eot_a, berr_a}, 32'd0);
      tick();
    end

    // Abort a 16-beat read after a few beats.
    begin_txn(1'b0, 32'h5000_0000, BE_ALL, 8'd15, 1'b1);
    tick();
    @(negedge clk);
    chk("abort_dv_pre0", 32'(dv_a), 32'd1);
    tick();
    @(negedge clk);
    chk("abort_dv_pre1", 32'(dv_a), 32'd1);
    tick();
    et_in = 1'b1;
    tick();
    et_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_dv", 32'(dv_a), 32'd0);
      chk("abort_eot", 32'(eot_a), 32'd0);
      tick();
    end
    rq = '{32'h11, 32'h22, 32'h33, 32'h44};
    read_burst(1'b0, 32'h5000_0010, 8'd3);

    // Asynchronous reset during a 16-beat read.
    begin_txn(1'b0, 32'h5000_0000, BE_ALL, 8'd15, 1'b1);
    tick();
    tick();
    @(negedge clk);
    chk("rst_mid_dv_pre", 32'(dv_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_dv", 32'(dv_a), 32'd0);
    chk("rst_mid_ad", ad_a, 32'd0);
    chk("rst_mid_eot", 32'(eot_a), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after_dv", 32'(dv_a), 32'd0);
    tick();
    read_burst(1'b0, 32'h5000_0010, 8'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
